// File: rtl/mem_stage_sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_stage_sram_ctrl_if
//
// Bundles the signals of the memory-access stage controller. The pipeline
// side and the external SRAM side share one interface instance.
//
//   Pipeline side
//     mem_r_en     load request from the EXE stage register
//     mem_w_en     store request from the EXE stage register
//     alu_res[31:0] byte address from the ALU
//     st_val[31:0]  store data
//     mem_val[31:0] loaded word (registered)
//     ready         1 = no access pending or access completing this cycle
//   SRAM side
//     sram_addr[17:0]   half-word address
//     sram_dq_out[15:0] write data
//     sram_dq_oe        1 = drive sram_dq_out onto the SRAM bus
//     sram_dq_in[15:0]  read data
//     sram_we_n         write enable, active low
//
// Modports: master = pipeline + SRAM environment, slave = controller.
// ---------------------------------------------------------------------------
interface mem_stage_sram_ctrl_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] alu_res;
  logic [31:0] st_val;
  logic [31:0] mem_val;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  modport master (
    output mem_r_en, mem_w_en, alu_res, st_val, sram_dq_in,
    input  mem_val, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  mem_r_en, mem_w_en, alu_res, st_val, sram_dq_in,
    output mem_val, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_sram_ctrl
//
// Memory-access stage of the pipeline. Each 32-bit load or store becomes two
// sequential 16-bit accesses on an external asynchronous SRAM, low half
// first. Each half phase lasts SRAM_WAIT+1 cycles. ready is low while an
// access is in flight (the top level uses ~ready as the pipeline freeze) and
// high for the single DONE cycle in which the access completes.
//
// Parameters
//   SRAM_WAIT  extra wait cycles per half access, 0..7
//   BASE_ADDR  byte address mapped to SRAM word 0
//
// Ports
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  mem_stage_sram_ctrl_if.slave (pipeline request/response + SRAM pins)
// ---------------------------------------------------------------------------
module mem_stage_sram_ctrl #(
  parameter int unsigned SRAM_WAIT = 1,
  parameter int unsigned BASE_ADDR = 1024
) (
  input logic                  clk,
  input logic                  rst,
  mem_stage_sram_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [2:0]  WAIT_C = 3'(SRAM_WAIT);
  localparam logic [31:0] BASE_C = 32'(BASE_ADDR);

  state_e      state_q,  state_d;
  logic [2:0]  cnt_q,    cnt_d;
  logic        wr_q,     wr_d;
  logic [16:0] word_q,   word_d;
  logic [31:0] st_val_q, st_val_d;
  logic [31:0] mem_val_q, mem_val_d;
  logic [17:0] addr_q,   addr_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        oe_q,     oe_d;
  logic        we_n_q,   we_n_d;

  logic        req;
  logic        last;
  logic [16:0] word_in;

  assign req  = bus.mem_r_en | bus.mem_w_en;
  assign last = (cnt_q == WAIT_C);

  // 32-bit subtract wraps on underflow; byte offset bits [1:0] are dropped
  assign word_in = 17'((bus.alu_res - BASE_C) >> 2);

  // SRAM pins are registered: the first half's address/data are loaded on
  // the IDLE->LOW edge so they are stable for the whole LOW phase.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    word_d    = word_q;
    st_val_d  = st_val_q;
    mem_val_d = mem_val_q;
    addr_d    = addr_q;
    dq_out_d  = dq_out_q;
    oe_d      = oe_q;
    we_n_d    = we_n_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          wr_d     = bus.mem_w_en;
          word_d   = word_in;
          st_val_d = bus.st_val;
          cnt_d    = '0;
          addr_d   = {word_in, 1'b0};
          dq_out_d = bus.st_val[15:0];
          oe_d     = bus.mem_w_en;
          we_n_d   = ~bus.mem_w_en;
          state_d  = LOW;
        end
      end

      LOW: begin
        if (last) begin
          if (!wr_q) begin
            mem_val_d[15:0] = bus.sram_dq_in;
          end
          cnt_d    = '0;
          addr_d   = {word_q, 1'b1};
          dq_out_d = st_val_q[31:16];
          state_d  = HIGH;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      HIGH: begin
        if (last) begin
          if (!wr_q) begin
            mem_val_d[31:16] = bus.sram_dq_in;
          end
          cnt_d   = '0;
          oe_d    = 1'b0;
          we_n_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      word_q    <= '0;
      st_val_q  <= '0;
      mem_val_q <= '0;
      addr_q    <= '0;
      dq_out_q  <= '0;
      oe_q      <= 1'b0;
      we_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      word_q    <= word_d;
      st_val_q  <= st_val_d;
      mem_val_q <= mem_val_d;
      addr_q    <= addr_d;
      dq_out_q  <= dq_out_d;
      oe_q      <= oe_d;
      we_n_q    <= we_n_d;
    end
  end

  // Low in the IDLE cycle that first sees a request so the freeze applies
  // to that same cycle.
  assign bus.ready       = (state_q == DONE) || ((state_q == IDLE) && !req);
  assign bus.mem_val     = mem_val_q;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_dq_out = dq_out_q;
  assign bus.sram_dq_oe  = oe_q;
  assign bus.sram_we_n   = we_n_q;

endmodule
